// File: rtl/nn_fxp_pkg.sv
// Fixed-point helpers shared by the sequential NN layer blocks.
// Contents: FSM state type, accumulator/index width helpers, output-size helper
// and the round-half-away-from-zero right shift used when leaving the accumulator.
package nn_fxp_pkg;

    // Widest accumulator the rounding helper handles.
    localparam int unsigned FXP_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN,
        DONE
    } seq_state_e;

    // Full-precision product plus enough headroom to sum every tap.
    function automatic int unsigned acc_width(input int unsigned width, input int unsigned taps);
        return 2 * width + $clog2(taps + 1);
    endfunction

    // Counter/index width that stays at least one bit for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Transposed-convolution output extent along one axis.
    function automatic int out_dim(input int in_dim, input int k, input int stride, input int pad);
        return (in_dim - 1) * stride - 2 * pad + k;
    endfunction

    // Drop frac fraction bits, rounding half away from zero.
    function automatic logic signed [FXP_W-1:0] fxp_round_shift(
        input logic signed [FXP_W-1:0] acc,
        input int                      frac
    );
        logic [FXP_W-1:0] mag;
        logic [FXP_W-1:0] r;
        if (frac <= 0) begin
            return acc;
        end
        mag = acc[FXP_W-1] ? FXP_W'(-acc) : FXP_W'(acc);
        r   = (mag + (FXP_W'(1) << (frac - 1))) >> frac;
        return acc[FXP_W-1] ? -$signed(r) : $signed(r);
    endfunction

endpackage

// File: rtl/tconv_idx_gen.sv
// Index generator for the sequential transposed convolution.
// Walks oc,oh,ow (advanced by step_out_i) and ic,kh,kw (advanced by step_tap_i),
// and decodes which input element / weight feeds the current tap.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   step_tap_i        advance the inner ic/kh/kw nest (wraps after the last tap)
//   step_out_i        advance the outer oc/oh/ow nest (wraps after the last element)
//   tap_valid_c       current tap lands on a real input sample
//   in_idx_c          flat CHW input index of that sample (0 when the tap is invalid)
//   w_idx_c           flat [IN_CH][OUT_CH][K][K] weight index
//   out_idx_c         flat CHW output index of the current element
//   oc_c              current output channel (bias select)
//   last_tap_c        inner nest is on its final tap
//   last_out_c        outer nest is on its final element
module tconv_idx_gen
    import nn_fxp_pkg::*;
#(
    parameter int          IN_CH   = 1,
    parameter int          OUT_CH  = 1,
    parameter int          IN_H    = 1,
    parameter int          IN_W    = 1,
    parameter int          K       = 3,
    parameter int          STRIDE  = 1,
    parameter int          PADDING = 0,
    parameter int unsigned IN_IW   = 1,
    parameter int unsigned W_IW    = 1,
    parameter int unsigned OUT_IW  = 1,
    parameter int unsigned OC_W    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_tap_i,
    input  logic              step_out_i,
    output logic              tap_valid_c,
    output logic [IN_IW-1:0]  in_idx_c,
    output logic [W_IW-1:0]   w_idx_c,
    output logic [OUT_IW-1:0] out_idx_c,
    output logic [OC_W-1:0]   oc_c,
    output logic              last_tap_c,
    output logic              last_out_c
);

    localparam int          OUT_H = out_dim(IN_H, K, STRIDE, PADDING);
    localparam int          OUT_W = out_dim(IN_W, K, STRIDE, PADDING);
    localparam int unsigned CH_W  = idx_width(IN_CH);
    localparam int unsigned K_W   = idx_width(K);
    localparam int unsigned OH_W  = idx_width(OUT_H);
    localparam int unsigned OW_W  = idx_width(OUT_W);

    logic [CH_W-1:0] ic_q;
    logic [K_W-1:0]  kh_q;
    logic [K_W-1:0]  kw_q;
    logic [OC_W-1:0] oc_q;
    logic [OH_W-1:0] oh_q;
    logic [OW_W-1:0] ow_q;

    logic ic_wrap, kh_wrap, kw_wrap, oc_wrap, oh_wrap, ow_wrap;
    int   t, u;

    assign ic_wrap = (ic_q == CH_W'(IN_CH - 1));
    assign kh_wrap = (kh_q == K_W'(K - 1));
    assign kw_wrap = (kw_q == K_W'(K - 1));
    assign oc_wrap = (oc_q == OC_W'(OUT_CH - 1));
    assign oh_wrap = (oh_q == OH_W'(OUT_H - 1));
    assign ow_wrap = (ow_q == OW_W'(OUT_W - 1));

    assign last_tap_c = ic_wrap && kh_wrap && kw_wrap;
    assign last_out_c = oc_wrap && oh_wrap && ow_wrap;
    assign oc_c       = oc_q;

    // Counter nests; both wrap to zero so the next tensor starts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            ic_q <= '0;
            kh_q <= '0;
            kw_q <= '0;
            oc_q <= '0;
            oh_q <= '0;
            ow_q <= '0;
        end else begin
            if (step_tap_i) begin
                if (kw_wrap) begin
                    kw_q <= '0;
                    if (kh_wrap) begin
                        kh_q <= '0;
                        ic_q <= ic_wrap ? '0 : ic_q + CH_W'(1);
                    end else begin
                        kh_q <= kh_q + K_W'(1);
                    end
                end else begin
                    kw_q <= kw_q + K_W'(1);
                end
            end
            if (step_out_i) begin
                if (ow_wrap) begin
                    ow_q <= '0;
                    if (oh_wrap) begin
                        oh_q <= '0;
                        oc_q <= oc_wrap ? '0 : oc_q + OC_W'(1);
                    end else begin
                        oh_q <= oh_q + OH_W'(1);
                    end
                end else begin
                    ow_q <= ow_q + OW_W'(1);
                end
            end
        end
    end

    // Gather form: output (oh,ow) pulls from input (t/S,u/S) when the stride grid lines up.
    always_comb begin
        t           = int'(oh_q) + PADDING - int'(kh_q);
        u           = int'(ow_q) + PADDING - int'(kw_q);
        tap_valid_c = (t >= 0) && (u >= 0)
                   && ((t % STRIDE) == 0) && ((u % STRIDE) == 0)
                   && ((t / STRIDE) < IN_H) && ((u / STRIDE) < IN_W);
        in_idx_c    = '0;
        if (tap_valid_c) begin
            in_idx_c = IN_IW'((int'(ic_q) * IN_H + t / STRIDE) * IN_W + u / STRIDE);
        end
        w_idx_c   = W_IW'(((int'(ic_q) * OUT_CH + int'(oc_q)) * K + int'(kh_q)) * K + int'(kw_q));
        out_idx_c = OUT_IW'((int'(oc_q) * OUT_H + int'(oh_q)) * OUT_W + int'(ow_q));
    end

endmodule

// File: rtl/conv_transpose2d_seq.sv
// Sequential fixed-point 2-D transposed convolution with one shared MAC.
// One flat CHW tensor in per handshake, one flat CHW tensor out per handshake;
// each output element costs TAPS MAC cycles plus one finish cycle.
// Weights ([IN_CH][OUT_CH][K][K]) and bias ([OUT_CH]) are packed parameter
// images, entry 0 in the least significant WIDTH bits.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid / in_ready   input handshake; in_vec is captured on acceptance
//   in_vec                signed input, element (c,h,w) at ((c*IN_H+h)*IN_W+w)*WIDTH
//   out_valid / out_ready output handshake; out_vec held while out_valid=1
//   out_vec               signed output, element (oc,oh,ow) at ((oc*OUT_H+oh)*OUT_W+ow)*WIDTH
module conv_transpose2d_seq
    import nn_fxp_pkg::*;
#(
    parameter int IN_CH   = 1,
    parameter int OUT_CH  = 1,
    parameter int IN_H    = 1,
    parameter int IN_W    = 1,
    parameter int K       = 3,
    parameter int STRIDE  = 1,
    parameter int PADDING = 0,
    parameter int WIDTH   = 16,
    parameter int FRAC    = 8,
    parameter logic [IN_CH*OUT_CH*K*K*WIDTH-1:0] WEIGHTS = '0,
    parameter logic [OUT_CH*WIDTH-1:0]           BIAS    = '0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [IN_CH*IN_H*IN_W*WIDTH-1:0]      in_vec,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [OUT_CH*out_dim(IN_H, K, STRIDE, PADDING)
                  *out_dim(IN_W, K, STRIDE, PADDING)*WIDTH-1:0] out_vec
);

    localparam int          OUT_H  = out_dim(IN_H, K, STRIDE, PADDING);
    localparam int          OUT_W  = out_dim(IN_W, K, STRIDE, PADDING);
    localparam int          TAPS   = IN_CH * K * K;
    localparam int          N_IN   = IN_CH * IN_H * IN_W;
    localparam int          N_W    = IN_CH * OUT_CH * K * K;
    localparam int          N_OUT  = OUT_CH * OUT_H * OUT_W;
    localparam int unsigned ACC_W  = acc_width(WIDTH, TAPS);
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned IN_IW  = idx_width(N_IN);
    localparam int unsigned W_IW   = idx_width(N_W);
    localparam int unsigned OUT_IW = idx_width(N_OUT);
    localparam int unsigned OC_W   = idx_width(OUT_CH);

    if (OUT_H <= 0 || OUT_W <= 0) begin : g_bad_geom
        $error("conv_transpose2d_seq: output height/width must be positive");
    end
    if (ACC_W > FXP_W) begin : g_bad_acc
        $error("conv_transpose2d_seq: accumulator wider than rounding helper");
    end

    seq_state_e                   state_q;
    logic                         in_ready_q;
    logic                         out_valid_q;
    logic [N_IN*WIDTH-1:0]        in_reg_q;
    logic [N_OUT*WIDTH-1:0]       out_vec_q;
    logic signed [ACC_W-1:0]      acc_q;

    logic                         tap_valid_c;
    logic [IN_IW-1:0]             in_idx_c;
    logic [W_IW-1:0]              w_idx_c;
    logic [OUT_IW-1:0]            out_idx_c;
    logic [OC_W-1:0]              oc_c;
    logic                         last_tap_c;
    logic                         last_out_c;

    logic signed [WIDTH-1:0]      x_c;
    logic signed [WIDTH-1:0]      w_c;
    logic signed [WIDTH-1:0]      b_c;
    logic signed [PROD_W-1:0]     prod_c;
    logic signed [ACC_W-1:0]      acc_tap_c;
    logic signed [ACC_W-1:0]      acc_fin_c;
    logic signed [WIDTH-1:0]      res_c;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_vec   = out_vec_q;

    tconv_idx_gen #(
        .IN_CH  (IN_CH),
        .OUT_CH (OUT_CH),
        .IN_H   (IN_H),
        .IN_W   (IN_W),
        .K      (K),
        .STRIDE (STRIDE),
        .PADDING(PADDING),
        .IN_IW  (IN_IW),
        .W_IW   (W_IW),
        .OUT_IW (OUT_IW),
        .OC_W   (OC_W)
    ) u_idx (
        .clk        (clk),
        .rst        (rst),
        .step_tap_i (state_q == CALC),
        .step_out_i (state_q == FIN),
        .tap_valid_c(tap_valid_c),
        .in_idx_c   (in_idx_c),
        .w_idx_c    (w_idx_c),
        .out_idx_c  (out_idx_c),
        .oc_c       (oc_c),
        .last_tap_c (last_tap_c),
        .last_out_c (last_out_c)
    );

    // Operand select and full-precision MAC.
    assign x_c       = in_reg_q[int'(in_idx_c)*WIDTH +: WIDTH];
    assign w_c       = WEIGHTS[int'(w_idx_c)*WIDTH +: WIDTH];
    assign b_c       = BIAS[int'(oc_c)*WIDTH +: WIDTH];
    assign prod_c    = PROD_W'(x_c) * PROD_W'(w_c);
    assign acc_tap_c = acc_q + ACC_W'(prod_c);

    // Bias is aligned to the product's binary point before rounding back to Q format.
    assign acc_fin_c = acc_q + (ACC_W'(b_c) <<< FRAC);
    assign res_c     = WIDTH'(fxp_round_shift(FXP_W'(acc_fin_c), FRAC));

    // Control FSM; out_valid rises one cycle after DONE is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            in_reg_q    <= '0;
            out_vec_q   <= '0;
            acc_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_reg_q   <= in_vec;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (tap_valid_c) begin
                        acc_q <= acc_tap_c;
                    end
                    if (last_tap_c) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    out_vec_q[int'(out_idx_c)*WIDTH +: WIDTH] <= res_c;
                    acc_q   <= '0;
                    state_q <= last_out_c ? DONE : CALC;
                end
                DONE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_transpose2d_seq.sv
// Bench for conv_transpose2d_seq: five instances cover the main geometries,
// stride/padding/bias, rounding and wrap, backpressure and mid-run reset.
module tb_conv_transpose2d_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  in_valid = '0;
    logic [4:0]  out_ready = '0;
    logic [4:0]  in_ready;
    logic [4:0]  out_valid;
    logic [63:0] iv [5];
    logic [255:0] ov [5];

    logic [143:0] ov_a;
    logic [255:0] ov_b;
    logic [143:0] ov_c;
    logic [15:0]  ov_d;
    logic [15:0]  ov_e;

    logic [15:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign ov[0] = 256'(ov_a);
    assign ov[1] = ov_b;
    assign ov[2] = 256'(ov_c);
    assign ov[3] = 256'(ov_d);
    assign ov[4] = 256'(ov_e);

    // A: 1x1 input, K=3, S=1, weights 1..9
    conv_transpose2d_seq #(.IN_CH(1), .OUT_CH(1), .IN_H(1), .IN_W(1), .K(3), .STRIDE(1), .PADDING(0),
        .WIDTH(16), .FRAC(8),
        .WEIGHTS({16'h0900, 16'h0800, 16'h0700, 16'h0600, 16'h0500, 16'h0400, 16'h0300, 16'h0200, 16'h0100}),
        .BIAS(16'h0000)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_vec(iv[0][15:0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_vec(ov_a));

    // B: 2x2 input, K=2, S=2 replication
    conv_transpose2d_seq #(.IN_CH(1), .OUT_CH(1), .IN_H(2), .IN_W(2), .K(2), .STRIDE(2), .PADDING(0),
        .WIDTH(16), .FRAC(8), .WEIGHTS({4{16'h0100}}), .BIAS(16'h0000)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_vec(iv[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_vec(ov_b));

    // C: 2x2 input, K=3, S=2, P=1, bias 1.0
    conv_transpose2d_seq #(.IN_CH(1), .OUT_CH(1), .IN_H(2), .IN_W(2), .K(3), .STRIDE(2), .PADDING(1),
        .WIDTH(16), .FRAC(8), .WEIGHTS({9{16'h0100}}), .BIAS(16'h0100)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_vec(iv[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_vec(ov_c));

    // D: 1x1, K=1, w = 1 LSB
    conv_transpose2d_seq #(.IN_CH(1), .OUT_CH(1), .IN_H(1), .IN_W(1), .K(1), .STRIDE(1), .PADDING(0),
        .WIDTH(16), .FRAC(8), .WEIGHTS(16'h0001), .BIAS(16'h0000)) u_d (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_vec(iv[3][15:0]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_vec(ov_d));

    // E: 1x1, K=1, w = 2.0
    conv_transpose2d_seq #(.IN_CH(1), .OUT_CH(1), .IN_H(1), .IN_W(1), .K(1), .STRIDE(1), .PADDING(0),
        .WIDTH(16), .FRAC(8), .WEIGHTS(16'h0200), .BIAS(16'h0000)) u_e (
        .clk(clk), .rst(rst), .in_valid(in_valid[4]), .in_ready(in_ready[4]), .in_vec(iv[4][15:0]),
        .out_valid(out_valid[4]), .out_ready(out_ready[4]), .out_vec(ov_e));

    // Present a tensor at the current negedge; it is taken on the next posedge.
    task automatic send(input int id, input logic [63:0] v);
        iv[id]       = v;
        in_valid[id] = 1'b1;
        @(negedge clk);
        in_valid[id] = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(input int id, output int n);
        n = 0;
        while (out_valid[id] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain(input int id);
        out_ready[id] = 1'b1;
        @(negedge clk);
        out_ready[id] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int id = 0; id < 5; id++) begin
            total++;
            if (in_ready[id] !== 1'b1) begin
                bad++; $display("FAIL reset_in_ready[%0d] got=%b want=1", id, in_ready[id]);
            end
            total++;
            if (out_valid[id] !== 1'b0) begin
                bad++; $display("FAIL reset_out_valid[%0d] got=%b want=0", id, out_valid[id]);
            end
            total++;
            if (ov[id] !== 256'd0) begin
                bad++; $display("FAIL reset_out_vec[%0d] got=%h want=0", id, ov[id]);
            end
        end
    endtask

    // 1x1 impulse through a 3x3 kernel reproduces the kernel.
    task automatic test_basic();
        int n;
        logic [15:0] e;
        for (int i = 0; i < 9; i++) exp_q.push_back(16'((i + 1) * 256));
        send(0, 64'h0100);
        wait_valid(0, n);
        total++;
        if (n !== 91) begin
            bad++; $display("FAIL basic_latency got=%0d want=91", n);
        end
        for (int i = 0; i < 9; i++) begin
            e = exp_q.pop_front();
            total++;
            if (ov[0][i*16 +: 16] !== e) begin
                bad++; $display("FAIL basic_out[%0d] got=%h want=%h", i, ov[0][i*16 +: 16], e);
            end
        end
        drain(0);
        total++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            bad++; $display("FAIL basic_handshake in_ready=%b out_valid=%b want 1/0", in_ready[0], out_valid[0]);
        end
    endtask

    task automatic test_stride_upsample();
        int n;
        logic [15:0] e;
        for (int oh = 0; oh < 4; oh++)
            for (int ow = 0; ow < 4; ow++)
                exp_q.push_back(16'(((oh / 2) * 2 + ow / 2 + 1) * 256));
        send(1, {16'h0400, 16'h0300, 16'h0200, 16'h0100});
        wait_valid(1, n);
        total++;
        if (n !== 81) begin
            bad++; $display("FAIL upsample_latency got=%0d want=81", n);
        end
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            total++;
            if (ov[1][i*16 +: 16] !== e) begin
                bad++; $display("FAIL upsample_out[%0d] got=%h want=%h", i, ov[1][i*16 +: 16], e);
            end
        end
        drain(1);
    endtask

    task automatic test_pad_bias();
        int n;
        logic [15:0] e;
        int tbl [9] = '{2, 3, 2, 3, 5, 3, 2, 3, 2};
        for (int i = 0; i < 9; i++) exp_q.push_back(16'(tbl[i] * 256));
        send(2, {4{16'h0100}});
        wait_valid(2, n);
        total++;
        if (n !== 91) begin
            bad++; $display("FAIL padbias_latency got=%0d want=91", n);
        end
        for (int i = 0; i < 9; i++) begin
            e = exp_q.pop_front();
            total++;
            if (ov[2][i*16 +: 16] !== e) begin
                bad++; $display("FAIL padbias_out[%0d] got=%h want=%h", i, ov[2][i*16 +: 16], e);
            end
        end
        drain(2);
    endtask

    task automatic test_rounding();
        int n;
        logic [15:0] e;
        logic [15:0] ins [3] = '{16'h0080, 16'hFF80, 16'h7F00};
        int          ids [3] = '{3, 3, 4};
        logic [15:0] outs[3] = '{16'h0001, 16'hFFFF, 16'hFE00};
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(outs[k]);
            send(ids[k], 64'(ins[k]));
            wait_valid(ids[k], n);
            total++;
            if (n !== 3) begin
                bad++; $display("FAIL round_latency[%0d] got=%0d want=3", k, n);
            end
            e = exp_q.pop_front();
            total++;
            if (ov[ids[k]][15:0] !== e) begin
                bad++; $display("FAIL round_out[%0d] got=%h want=%h", k, ov[ids[k]][15:0], e);
            end
            drain(ids[k]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [15:0] e;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 9; i++)
                exp_q.push_back(pass == 0 ? 16'((i + 1) * 512) : 16'(-(i + 1) * 256));
            send(0, pass == 0 ? 64'h0200 : 64'hFF00);
            wait_valid(0, n);
            total++;
            if (n !== 91) begin
                bad++; $display("FAIL b2b_latency[%0d] got=%0d want=91", pass, n);
            end
            for (int i = 0; i < 9; i++) begin
                e = exp_q.pop_front();
                total++;
                if (ov[0][i*16 +: 16] !== e) begin
                    bad++; $display("FAIL b2b_out[%0d][%0d] got=%h want=%h", pass, i, ov[0][i*16 +: 16], e);
                end
            end
            drain(0);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [143:0] expv;
        for (int i = 0; i < 9; i++) expv[i*16 +: 16] = 16'((i + 1) * 512);
        send(0, 64'h0200);
        wait_valid(0, n);
        total++;
        if (n !== 91) begin
            bad++; $display("FAIL bp_latency got=%0d want=91", n);
        end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 40) begin
                iv[0] = 64'h0500;
                in_valid[0] = 1'b1;
            end
            if (c == 42) in_valid[0] = 1'b0;
            if (c % 10 == 9) begin
                total++;
                if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
                    bad++; $display("FAIL bp_hold[%0d] out_valid=%b in_ready=%b want 1/0", c, out_valid[0], in_ready[0]);
                end
                total++;
                if (ov[0][143:0] !== expv) begin
                    bad++; $display("FAIL bp_stable[%0d] got=%h want=%h", c, ov[0][143:0], expv);
                end
            end
        end
        drain(0);
        total++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            bad++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready[0], out_valid[0]);
        end
        repeat (5) @(negedge clk);
        total++;
        if (in_ready[0] !== 1'b1) begin
            bad++; $display("FAIL bp_no_ghost in_ready=%b want=1", in_ready[0]);
        end
    endtask

    task automatic test_reset_mid_calc();
        send(0, 64'h0100);
        repeat (25) @(negedge clk);
        total++;
        if (in_ready[0] !== 1'b0) begin
            bad++; $display("FAIL midrst_busy in_ready=%b want=0", in_ready[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            bad++; $display("FAIL midrst_ctrl out_valid=%b in_ready=%b want 0/1", out_valid[0], in_ready[0]);
        end
        total++;
        if (ov[0] !== 256'd0) begin
            bad++; $display("FAIL midrst_out_vec got=%h want=0", ov[0]);
        end
        test_basic();
    endtask

    initial begin
        for (int i = 0; i < 5; i++) iv[i] = '0;
        test_reset();
        test_basic();
        test_stride_upsample();
        test_pad_bias();
        test_rounding();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_calc();
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
